// File: rtl/gpio_key_pkg.sv
// gpio_key_pkg: shared types and defaults for the GPIO key capture stage.
package gpio_key_pkg;

    // Default width of a player key code.
    localparam int DEFAULT_DATA_W = 8;

    // Debounce FSM states: waiting, confirming a press, held, confirming a release.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } key_state_t;

endpackage

// File: rtl/key_sync_2ff.sv
// key_sync_2ff: two-flop synchroniser for an asynchronous bus.
// Each bit is synchronised independently; callers must tolerate bit skew.
module key_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give metastability a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gpio_key_capture.sv
// gpio_key_capture: synchronises, debounces and captures GPIO key codes,
// presenting them to the CPU through a show-ahead valid/read interface.
// Build option: define GPIO_KEY_FIFO_EN for a FIFO_DEPTH-entry circular
// buffer; otherwise storage is a single holding register.
module gpio_key_capture
    import gpio_key_pkg::*;
#(
    parameter int DATA_W          = DEFAULT_DATA_W,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] key_data,
    input  logic              key_strobe,
    input  logic              rd_en,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Both parameters are checked in either build so that toggling the
    // storage option never changes which parameter sets are legal.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("gpio_key_capture: DEBOUNCE_CYCLES must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("gpio_key_capture: FIFO_DEPTH must be a power of two, at least 2");
    end

    logic [DATA_W:0]   sync_q;
    logic              s_strobe;
    logic [DATA_W-1:0] s_data;

    key_sync_2ff #(
        .WIDTH (DATA_W + 1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({key_strobe, key_data}),
        .q   (sync_q)
    );

    assign s_strobe = sync_q[DATA_W];
    assign s_data   = sync_q[DATA_W-1:0];

    key_state_t        state;
    key_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              capture;

    // Debounce state and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Press must stay high, and release stay low, for DEBOUNCE_CYCLES samples; one capture per press.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (s_strobe) begin
                    state_nxt = ARMING;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ARMING: begin
                if (!s_strobe) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s_strobe) begin
                    state_nxt = RELEASING;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RELEASING: begin
                if (s_strobe) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    logic              cap_valid;
    logic [DATA_W-1:0] cap_data;

    // Register the capture so storage is written one edge after the confirming sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= capture;
            if (capture) begin
                cap_data <= s_data;
            end
        end
    end

    logic do_pop;
    logic do_write;
    logic set_ovr;

`ifdef GPIO_KEY_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;

    assign full = (count == CNT_FULL);

    // A pop frees the slot a simultaneous capture needs; a pop on empty is ignored.
    always_comb begin
        do_pop   = rd_en && (count != '0);
        do_write = cap_valid && (!full || do_pop);
        set_ovr  = cap_valid && full && !do_pop;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_write && !do_pop) begin
                count <= count + COUNT_ONE;
            end else if (do_pop && !do_write) begin
                count <= count - COUNT_ONE;
            end
        end
    end

    // Entry storage has no reset; unread slots are masked by valid.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= cap_data;
        end
    end

    assign valid    = (count != '0);
    assign data_out = valid ? mem[rd_ptr] : '0;
`else
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;

    // Single register: full whenever it holds a code, unless it is read in the same cycle.
    always_comb begin
        do_pop   = rd_en && hold_valid;
        do_write = cap_valid && (!hold_valid || do_pop);
        set_ovr  = cap_valid && hold_valid && !do_pop;
    end

    // Holding register; a write in the same cycle as a pop replaces the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (do_write) begin
            hold_valid <= 1'b1;
            hold_data  <= cap_data;
        end else if (do_pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign valid    = hold_valid;
    assign data_out = hold_valid ? hold_data : '0;
`endif

    // Sticky overrun flag; a new drop takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (set_ovr) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_key_capture.sv
// tb_gpio_key_capture: directed and randomised checks of gpio_key_capture
// against a run-length reference model with a queue scoreboard.
module tb_gpio_key_capture;

    localparam int DATA_W = 8;
    localparam int DEB    = 16;
    localparam int DEPTH  = 4;
`ifdef GPIO_KEY_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] key_data = '0;
    logic              key_strobe = 1'b0;
    logic              rd_en = 1'b0;
    logic              clr_ovr = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              overrun;

    gpio_key_capture #(
        .DATA_W          (DATA_W),
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_data   (key_data),
        .key_strobe (key_strobe),
        .rd_en      (rd_en),
        .clr_ovr    (clr_ovr),
        .data_out   (data_out),
        .valid      (valid),
        .overrun    (overrun)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int num_checks = 0;
    int num_fail   = 0;
    bit mon_en     = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: a press is the DEB-th consecutive high raw sample while
    // armed; it lands in storage three edges later (two sync stages plus the
    // capture register). Re-arming needs DEB consecutive low raw samples.
    typedef struct {
        int                t;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               wsched[$];
    logic [DATA_W-1:0] sb_q[$];
    bit                m_ovr  = 1'b0;
    bit                armed  = 1'b1;
    int                hi_run = 0;
    int                lo_run = 0;
    int                cyc    = 0;

    // Model update on every active edge from the inputs driven before it.
    always @(posedge clk) begin
        bit popped;
        bit dropped;
        cyc++;
        if (rst) begin
            wsched.delete();
            sb_q.delete();
            m_ovr  = 1'b0;
            armed  = 1'b1;
            hi_run = 0;
            lo_run = 0;
        end else begin
            popped  = 1'b0;
            dropped = 1'b0;
            if (rd_en && sb_q.size() > 0) begin
                void'(sb_q.pop_front());
                popped = 1'b1;
            end
            if (wsched.size() > 0 && wsched[0].t == cyc) begin
                if (sb_q.size() < CAP) sb_q.push_back(wsched[0].d);
                else dropped = 1'b1;
                void'(wsched.pop_front());
            end
            if (dropped && !popped) m_ovr = 1'b1;
            else if (clr_ovr) m_ovr = 1'b0;

            if (armed) begin
                if (key_strobe) begin
                    hi_run++;
                    if (hi_run == DEB) begin
                        wsched.push_back('{t: cyc + 3, d: key_data});
                        armed  = 1'b0;
                        lo_run = 0;
                    end
                end else begin
                    hi_run = 0;
                end
            end else begin
                if (!key_strobe) begin
                    lo_run++;
                    if (lo_run == DEB) begin
                        armed  = 1'b1;
                        hi_run = 0;
                    end
                end else begin
                    lo_run = 0;
                end
            end
        end
    end

    // Monitor: compare DUT outputs with the scoreboard head every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("sb valid", 32'(valid), 32'(sb_q.size() > 0));
            checkOutput("sb data_out", 32'(data_out), (sb_q.size() > 0) ? 32'(sb_q[0]) : 32'd0);
            checkOutput("sb overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    // One press: strobe high for hi cycles with a fixed code, then low for lo cycles.
    task automatic applyStimulus(input logic [DATA_W-1:0] code, input int hi, input int lo);
        key_data   = code;
        key_strobe = 1'b1;
        repeat (hi) @(negedge clk);
        key_strobe = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic readOne(input logic [DATA_W-1:0] exp, input string name);
        checkOutput({name, " valid"}, 32'(valid), 32'd1);
        checkOutput({name, " data"}, 32'(data_out), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Edges from the first one that samples the new stimulus until valid is seen.
    task automatic measureLatency(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (valid) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int len;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Idle after reset.
        repeat (100) @(negedge clk);
        checkOutput("idle valid", 32'(valid), 32'd0);
        checkOutput("idle data_out", 32'(data_out), 32'd0);
        checkOutput("idle overrun", 32'(overrun), 32'd0);

        // Long hold: one capture only, latency DEB+2.
        key_data   = 8'hFC;
        key_strobe = 1'b1;
        measureLatency(lat);
        checkOutput("press latency", 32'(lat), 32'(DEB + 2));
        checkOutput("press data", 32'(data_out), 32'hFC);
        repeat (10000 - lat - 1) @(negedge clk);
        key_strobe = 1'b0;
        repeat (DEB + 5) @(negedge clk);
        readOne(8'hFC, "long press");
        checkOutput("long press one entry", 32'(valid), 32'd0);

        // Glitch shorter than the debounce window.
        applyStimulus(8'h5A, 10, 30);
        checkOutput("glitch no capture", 32'(valid), 32'd0);

        // Bounce during release gives a single capture.
        applyStimulus(8'h3C, 40, 5);
        applyStimulus(8'h3C, 3, 40);
        readOne(8'h3C, "bounce");
        checkOutput("bounce one entry", 32'(valid), 32'd0);

        // Five presses without reads: storage fills, extra presses overrun.
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), DEB + 5, DEB + 5);
        checkOutput("overflow overrun", 32'(overrun), 32'd1);
        for (int i = 1; i <= CAP; i++) readOne(8'(i), "overflow read");
        checkOutput("overflow drained", 32'(valid), 32'd0);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        checkOutput("clr_ovr", 32'(overrun), 32'd0);

        // Full storage, capture coincides with a read: no overrun.
        for (int i = 1; i <= CAP; i++) applyStimulus(8'(i), DEB + 5, DEB + 5);
        checkOutput("full before", 32'(valid), 32'd1);
        key_data   = 8'h05;
        key_strobe = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        key_strobe = 1'b0;
        repeat (DEB + 5) @(negedge clk);
        checkOutput("write+pop overrun", 32'(overrun), 32'd0);
        for (int i = 2; i <= CAP; i++) readOne(8'(i), "write+pop read");
        readOne(8'h05, "write+pop last");
        checkOutput("write+pop drained", 32'(valid), 32'd0);

        // Reset during ARMING: entry discarded, held strobe re-arms.
        applyStimulus(8'h77, DEB + 5, DEB + 5);
        key_data   = 8'hA5;
        key_strobe = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst clears valid", 32'(valid), 32'd0);
        checkOutput("rst clears data", 32'(data_out), 32'd0);
        measureLatency(lat);
        checkOutput("rst re-arm latency", 32'(lat), 32'(DEB + 2));
        checkOutput("rst re-arm data", 32'(data_out), 32'hA5);
        key_strobe = 1'b0;
        repeat (DEB + 5) @(negedge clk);
        readOne(8'hA5, "rst re-arm read");
        checkOutput("rst re-arm one entry", 32'(valid), 32'd0);

        // Randomised phase checked by the scoreboard.
        for (int seg = 0; seg < 80; seg++) begin
            len        = $urandom_range(1, 2 * DEB + 4);
            key_strobe = ~key_strobe;
            for (int c = 0; c < len; c++) begin
                key_data = DATA_W'($urandom);
                rd_en    = ($urandom_range(0, 3) == 0);
                clr_ovr  = ($urandom_range(0, 15) == 0);
                rst      = ($urandom_range(0, 399) == 0);
                @(negedge clk);
            end
        end
        rst        = 1'b0;
        clr_ovr    = 1'b0;
        key_strobe = 1'b0;
        rd_en      = 1'b1;
        repeat (DEB + 10) @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        checkOutput("final drained", 32'(valid), 32'd0);
        checkOutput("final data_out", 32'(data_out), 32'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
